// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel stream in, window matrix + strobes out.
//   master: pixel source (drives pix_*, observes win_*/frame_done)
//   slave : window generator (consumes pix_*, drives win_*/frame_done)
interface conv_window_gen_if #(
   parameter int SIZE      = 3,
   parameter int WIDTH_BIT = 8
);
   logic                                        pix_valid;
   logic                                        pix_sof;
   logic [WIDTH_BIT-1:0]                        pix_data;
   logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]    win_matrix;
   logic                                        win_valid;
   logic                                        frame_done;
   modport master (output pix_valid, pix_sof, pix_data, input win_matrix, win_valid, frame_done);
   modport slave  (input pix_valid, pix_sof, pix_data, output win_matrix, win_valid, frame_done);
endinterface

// File: rtl/conv_window_gen.sv
// conv_window_gen: SIZExSIZE sliding-window generator over a raster pixel stream.
//   clock, reset (async, active-high)
//   bus.pix_valid/pix_sof/pix_data : accepted pixel stream, sof marks (0,0)
//   bus.win_matrix : window, [SIZE-1][SIZE-1] is the newest pixel
//   bus.win_valid  : one-cycle strobe for each complete, unpadded window
//   bus.frame_done : one-cycle strobe with the window of the frame's last pixel
module conv_window_gen #(
   parameter int SIZE      = 3,
   parameter int WIDTH_BIT = 8,
   parameter int IMG_W     = 8,
   parameter int IMG_H     = 8
) (
   input logic              clock,
   input logic              reset,
   conv_window_gen_if.slave bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   logic [CW-1:0] col, pc, nc;
   logic [RW-1:0] row, pr, nr;
   logic [0:0] state;
   logic acc, sof, lst_col, lst;
   logic [WIDTH_BIT-1:0] lb [SIZE-1][IMG_W];
   logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] win;
   logic wv, fd;
   assign acc = bus.pix_valid;
   assign sof = bus.pix_valid & bus.pix_sof;
   // position of the pixel being accepted; sof overrides the counters
   always_comb begin
      pc      = sof ? '0 : col;
      pr      = sof ? '0 : row;
      lst_col = pc == CW'(IMG_W - 1);
      lst     = lst_col && pr == RW'(IMG_H - 1);
      nc      = lst_col ? '0 : pc + 1'b1;
      nr      = lst_col ? (lst ? '0 : pr + 1'b1) : pr;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col   <= '0;
         row   <= '0;
         state <= FILL;
         wv    <= 1'b0;
         fd    <= 1'b0;
         win   <= '0;
         for (int k = 0; k < SIZE - 1; k++)
            for (int j = 0; j < IMG_W; j++)
               lb[k][j] <= '0;
      end else begin
         // columns below SIZE-1 straddle the line wrap and are never flagged
         wv <= acc && !sof && state == RUN && pc >= CW'(SIZE - 1);
         fd <= acc && !sof && state == RUN && lst;
         if (acc) begin
            col   <= nc;
            row   <= nr;
            state <= sof ? FILL :
                     (state == FILL && pr == RW'(SIZE - 2) && lst_col) ? RUN :
                     (state == RUN && lst) ? FILL : state;
            // each line delays by exactly one image row
            for (int k = 0; k < SIZE - 1; k++)
               for (int j = IMG_W - 1; j > 0; j--)
                  lb[k][j] <= lb[k][j-1];
            lb[0][0] <= bus.pix_data;
            for (int k = 1; k < SIZE - 1; k++)
               lb[k][0] <= lb[k-1][IMG_W-1];
            for (int i = 0; i < SIZE; i++)
               for (int j = 0; j < SIZE - 1; j++)
                  win[i][j] <= win[i][j+1];
            // oldest line feeds the top window row
            for (int i = 0; i < SIZE - 1; i++)
               win[i][SIZE-1] <= lb[SIZE-2-i][IMG_W-1];
            win[SIZE-1][SIZE-1] <= bus.pix_data;
         end
      end
   end
   assign bus.win_matrix = win;
   assign bus.win_valid  = wv;
   assign bus.frame_done = fd;
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: randomized self-checking bench against a pixel-history model.
module tb_conv_window_gen;
   localparam int S  = 3;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int WB = 8;
   localparam logic [71:0] FIRST = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
   localparam logic [71:0] LAST  = {8'd16, 8'd15, 8'd14, 8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd6};
   logic clock = 1'b0;
   logic reset = 1'b1;
   conv_window_gen_if #(.SIZE(S), .WIDTH_BIT(WB)) bus ();
   conv_window_gen #(.SIZE(S), .WIDTH_BIT(WB), .IMG_W(W), .IMG_H(H)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );
   always #5 clock = ~clock;
   int n_cmp = 0;
   int n_bad = 0;
   int r = 0;
   int c = 0;
   logic ev = 1'b0;
   logic ed = 1'b0;
   logic [WB-1:0] hist [$];
   int nv, nd;
   logic [71:0] first, last;
   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask
   // window = accepted-pixel history, offset by whole lines (rows) and single pixels (columns)
   function automatic logic [71:0] exp_win();
      logic [S-1:0][S-1:0][WB-1:0] m;
      for (int i = 0; i < S; i++)
         for (int j = 0; j < S; j++) begin
            int k = hist.size() - 1 - (S - 1 - i) * W - (S - 1 - j);
            m[i][j] = k >= 0 ? hist[k] : '0;
         end
      return m;
   endfunction
   task automatic cyc(input logic v, input logic s, input logic [WB-1:0] d);
      bus.pix_valid = v;
      bus.pix_sof   = s;
      bus.pix_data  = d;
      @(posedge clock);
      if (v) begin
         if (s) begin
            r = 0;
            c = 0;
         end
         ev = r >= S - 1 && c >= S - 1;
         ed = !s && r == H - 1 && c == W - 1;
         hist.push_back(d);
         if (c == W - 1) begin
            c = 0;
            r = r == H - 1 ? 0 : r + 1;
         end else c++;
      end else begin
         ev = 1'b0;
         ed = 1'b0;
      end
      @(negedge clock);
      check("win_valid", 72'(bus.win_valid), 72'(ev));
      check("frame_done", 72'(bus.frame_done), 72'(ed));
      check("win_matrix", bus.win_matrix, exp_win());
      if (bus.win_valid) begin
         nv++;
         if (nv == 1) first = bus.win_matrix;
         last = bus.win_matrix;
      end
      if (bus.frame_done) nd++;
   endtask
   task automatic send(input int from, input int upto, input bit gaps);
      for (int p = from; p <= upto; p++) begin
         for (int g = 0; gaps && g < 4 && $urandom_range(0, 1) == 1; g++)
            cyc(1'b0, 1'b0, 8'($urandom));
         cyc(1'b1, p == 1, 8'(p));
      end
   endtask
   task automatic clr();
      nv = 0;
      nd = 0;
      first = '0;
      last = '0;
   endtask
   task automatic frame_checks(input string tag, input int wins, input int dones);
      check({tag, "_windows"}, 72'(nv), 72'(wins));
      check({tag, "_dones"}, 72'(nd), 72'(dones));
      check({tag, "_first"}, first, FIRST);
      check({tag, "_last"}, last, LAST);
   endtask
   initial begin
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      bus.pix_data  = '0;
      repeat (2) @(negedge clock);
      check("rst_valid", 72'(bus.win_valid), 72'(0));
      check("rst_done", 72'(bus.frame_done), 72'(0));
      check("rst_matrix", bus.win_matrix, '0);
      reset = 1'b0;
      clr();
      send(1, 16, 1'b0);
      frame_checks("b2b", 4, 1);
      clr();
      send(1, 16, 1'b1);
      frame_checks("gaps", 4, 1);
      clr();
      send(1, 10, 1'b0);
      #1 reset = 1'b1;
      #1;
      check("async_valid", 72'(bus.win_valid), 72'(0));
      check("async_done", 72'(bus.frame_done), 72'(0));
      check("async_matrix", bus.win_matrix, '0);
      hist.delete();
      r = 0;
      c = 0;
      @(negedge clock);
      check("held_matrix", bus.win_matrix, '0);
      reset = 1'b0;
      send(1, 16, 1'b0);
      frame_checks("rst_restart", 4, 1);
      clr();
      send(1, 6, 1'b0);
      send(1, 16, 1'b1);
      frame_checks("resof", 4, 1);
      clr();
      send(1, 16, 1'b0);
      send(1, 16, 1'b0);
      frame_checks("two", 8, 2);
      for (int t = 0; t < 400; t++)
         cyc(1'(($urandom_range(0, 3) != 0)), 1'(($urandom_range(0, 23) == 0)), 8'($urandom));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Sliding-window generator that feeds the convolution datapath. It accepts a raster-order pixel stream (one pixel per cycle, with gaps allowed) and buffers SIZE-1 previous image lines. For every pixel that completes a full SIZE×SIZE neighbourhood it presents the window matrix and a one-cycle valid strobe, which drive the convolution unit's matrix input and enable. Only valid (unpadded) windows are produced, so each frame yields (IMG_W-SIZE+1)·(IMG_H-SIZE+1) windows.

## Interface
Parameters:
- SIZE, 3: window edge length; must match the convolution unit.
- WIDTH_BIT, 8: pixel width in bits.
- IMG_W, 8: image width in pixels; IMG_W ≥ SIZE.
- IMG_H, 8: image height in lines; IMG_H ≥ SIZE.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high reset.
- pix_valid, in, 1: pixel present on pix_data this cycle.
- pix_sof, in, 1: start of frame. Qualified by pix_valid; marks the pixel at (0,0).
- pix_data, in, WIDTH_BIT: pixel value.
- win_matrix, out, WIDTH_BIT × [SIZE][SIZE]: current window. [i][j] = image(row-SIZE+1+i, col-SIZE+1+j); [SIZE-1][SIZE-1] is the newest pixel.
- win_valid, out, 1: one-cycle strobe; win_matrix is a complete valid window.
- frame_done, out, 1: one-cycle strobe, registered with the window of the last pixel (IMG_H-1, IMG_W-1).

## Operation
- Accept: a pixel is accepted on every rising edge with pix_valid=1. There is no backpressure.
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1), each $clog2 bits wide. col advances on each accepted pixel. At IMG_W-1, col wraps to 0 and row increments. At (IMG_H-1, IMG_W-1) both wrap to 0.
- pix_sof=1 on an accepted pixel forces that pixel's position to (0,0), whatever the counter values. The counters then continue from (0,1).
- Line buffers: SIZE-1 shift lines, each IMG_W deep. On accept:
  - the newest pixel enters line 0;
  - line k's output enters line k+1.
- Window shift: on accept, each window row shifts left one column. Column SIZE-1 loads {line SIZE-2 out, …, line 0 out, pix_data} into rows 0..SIZE-1.
- FSM states:
  - FILL: row < SIZE-1. No windows are emitted. Moves to RUN when the pixel at (SIZE-2, IMG_W-1) is accepted.
  - RUN: win_valid fires for accepted pixels with col ≥ SIZE-1. Returns to FILL after the last pixel of the frame is accepted, and asserts frame_done with that window.
  - pix_sof always forces FILL. The forced pixel is treated as row 0.
- Line wrap: windows whose column index is below SIZE-1 mix pixels from the previous line. Their win_valid is suppressed; the stale data is never flagged valid.
- No pixel: when pix_valid=0, the counters, window and line buffers hold, and win_valid and frame_done are 0.
- Arithmetic: data is moved only, never modified. There is no overflow case.

## Timing
- Latency: win_matrix and win_valid are registered one cycle after the accepting edge.
  - win_matrix holds until the next accepted pixel.
  - win_valid is high for exactly one cycle per qualifying pixel.
- Throughput: one window per cycle during back-to-back RUN pixels.
- Reset values (asynchronous): win_matrix all 0, win_valid 0, frame_done 0, col 0, row 0, state FILL. Line buffers also clear to 0.
- Reset mid-frame: the frame is aborted immediately. The next accepted pixel is (0,0). No window is emitted until SIZE-1 full lines plus SIZE pixels have arrived.
- pix_sof mid-frame: the same resynchronisation as reset, but the line buffer contents are kept. They are overwritten before any window is flagged valid.
- Simultaneous events: pix_sof on the last pixel of a frame takes priority. That pixel is (0,0) and frame_done is not asserted.

## Test plan
Common setup for all tests: SIZE=3, IMG_W=4, IMG_H=4. Pixels are value 4r+c+1 (1..16), with pix_sof on pixel 1.

- Back-to-back frame:
  - Exactly 4 win_valid pulses, one cycle after pixels 11, 12, 15, 16.
  - The first window is rows {1,2,3},{5,6,7},{9,10,11}.
  - The last window is {6,7,8},{10,11,12},{14,15,16}, with frame_done high in the same cycle.
- Random pix_valid gaps (≈50% duty): the same 4 windows with identical contents. win_matrix is stable between accepts, and there are no extra pulses.
- Line wrap: check that there is no win_valid after pixels 9, 10, 13 or 14. These windows contain pixels from the previous line.
- Reset asserted asynchronously after pixel 10, then the frame is restarted:
  - All outputs read 0 while reset is high.
  - After restart, the first valid window again appears one cycle after pixel 11 and contains 1..11 data as above.
- pix_sof reasserted on pixel 7 and the frame is streamed from there:
  - There is no window from the aborted frame.
  - Windows are produced only after 11 pixels of the new frame.
- Two consecutive frames with no gap: 8 windows in total. frame_done pulses exactly twice. Frame-2 windows match frame 1.
